// File: rtl/branch_predict_unit_if.sv
// Fetch lookup, execute-stage resolution and debug signals of the branch predict unit.
// master = fetch/execute side, slave = predictor.
interface branch_predict_unit_if #(
    parameter int RAS_DEPTH = 8
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic [31:0]      fetch_pc;
    logic             pred_hit;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic             upd_ready;
    logic             upd_branch;
    logic             upd_call;
    logic             upd_return;
    logic             upd_taken;
    logic [31:0]      upd_target;
    logic [31:0]      upd_pc;
    logic [CNT_W-1:0] ras_count;

    modport master (
        output fetch_pc, upd_ready, upd_branch, upd_call, upd_return,
               upd_taken, upd_target, upd_pc,
        input  pred_hit, pred_taken, pred_target, ras_count
    );

    modport slave (
        input  fetch_pc, upd_ready, upd_branch, upd_call, upd_return,
               upd_taken, upd_target, upd_pc,
        output pred_hit, pred_taken, pred_target, ras_count
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit counters, trained at commit; the return address stack
// is built only when BPU_RAS_EN is defined (otherwise RET entries use the BTB target).
module branch_predict_unit #(
    parameter int BTB_ENTRIES = 16,
    parameter int RAS_DEPTH   = 8
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    branch_predict_unit_if.slave  bus
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {
        BR_COND = 2'd0,
        BR_JUMP = 2'd1,
        BR_CALL = 2'd2,
        BR_RET  = 2'd3
    } br_type_e;

    // BTB storage
    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [31:0]            target_q [BTB_ENTRIES];
    logic [1:0]             cnt_q    [BTB_ENTRIES];
    br_type_e               type_q   [BTB_ENTRIES];

    logic             commit;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             btb_wr;
    br_type_e         upd_type;
    logic [1:0]       cnt_d;

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic             f_taken;
    br_type_e         f_type;

    logic             ras_valid;
    logic [31:0]      ras_top;
    logic             unused_bits;

    assign unused_bits = ^{bus.fetch_pc[1:0], bus.upd_pc[1:0]};

    assign commit  = bus.upd_ready & bus.upd_branch;
    assign upd_idx = bus.upd_pc[IDX_W+1:2];
    assign upd_tag = bus.upd_pc[31:IDX_W+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    // A not-taken miss never allocates.
    assign btb_wr  = commit && (upd_hit || bus.upd_taken);

    always_comb begin
        upd_type = BR_COND;
        if (bus.upd_return) begin
            upd_type = BR_RET;
        end else if (bus.upd_call) begin
            upd_type = BR_CALL;
        end
    end

    always_comb begin
        cnt_d = 2'b10;
        if (upd_hit) begin
            if (bus.upd_taken) begin
                cnt_d = (cnt_q[upd_idx] == 2'b11) ? 2'b11 : cnt_q[upd_idx] + 2'b01;
            end else begin
                cnt_d = (cnt_q[upd_idx] == 2'b00) ? 2'b00 : cnt_q[upd_idx] - 2'b01;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            valid_q <= '0;
        end else if (btb_wr) begin
            valid_q[upd_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RSTN && btb_wr) begin
            tag_q[upd_idx]  <= upd_tag;
            cnt_q[upd_idx]  <= cnt_d;
            type_q[upd_idx] <= upd_type;
            if (bus.upd_taken) begin
                target_q[upd_idx] <= bus.upd_target;
            end
        end
    end

    // Lookup reads the pre-commit state only.
    assign f_idx   = bus.fetch_pc[IDX_W+1:2];
    assign f_tag   = bus.fetch_pc[31:IDX_W+2];
    assign f_hit   = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign f_type  = type_q[f_idx];
    assign f_taken = f_hit && ((f_type != BR_COND) || cnt_q[f_idx][1]);

    assign bus.pred_hit    = f_hit;
    assign bus.pred_taken  = f_taken;
    assign bus.pred_target = !f_taken ? 32'd0 :
                             ((f_type == BR_RET) && ras_valid) ? ras_top : target_q[f_idx];

`ifdef BPU_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      ras_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;
    logic [PTR_W-1:0] top_idx;
    logic             ras_wr;
    logic [PTR_W-1:0] ras_wr_idx;
    logic [31:0]      ret_addr;

    assign ret_addr = bus.upd_pc + 32'd4;
    assign top_idx  = ptr_q - PTR_W'(1);

    // ptr_q is the next free slot; a push into a full stack overwrites the oldest entry.
    always_comb begin
        ptr_d      = ptr_q;
        ras_cnt_d  = ras_cnt_q;
        ras_wr     = 1'b0;
        ras_wr_idx = ptr_q;
        if (commit) begin
            if (bus.upd_call && bus.upd_return) begin
                ras_wr = 1'b1;
                if (ras_cnt_q == '0) begin
                    ptr_d     = ptr_q + PTR_W'(1);
                    ras_cnt_d = CNT_W'(1);
                end else begin
                    ras_wr_idx = top_idx;
                end
            end else if (bus.upd_call) begin
                ras_wr = 1'b1;
                ptr_d  = ptr_q + PTR_W'(1);
                if (ras_cnt_q != CNT_W'(RAS_DEPTH)) begin
                    ras_cnt_d = ras_cnt_q + CNT_W'(1);
                end
            end else if (bus.upd_return && (ras_cnt_q != '0)) begin
                ptr_d     = top_idx;
                ras_cnt_d = ras_cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            ptr_q     <= '0;
            ras_cnt_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RSTN && ras_wr) begin
            ras_q[ras_wr_idx] <= ret_addr;
        end
    end

    assign ras_valid     = (ras_cnt_q != '0);
    assign ras_top       = ras_q[top_idx];
    assign bus.ras_count = ras_cnt_q;
`else
    assign ras_valid     = 1'b0;
    assign ras_top       = 32'd0;
    assign bus.ras_count = {($clog2(RAS_DEPTH) + 1){1'b0}};
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios plus randomized traffic
// compared against an entry/queue-level reference model of the predictor.
`timescale 1ns/1ps
module tb_branch_predict_unit;
    localparam int BTB_ENTRIES = 16;
    localparam int RAS_DEPTH   = 8;
    localparam int RC_W        = $clog2(RAS_DEPTH) + 1;
    localparam int K_COND = 0, K_CALL = 2, K_RET = 3;
`ifdef BPU_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    branch_predict_unit_if #(.RAS_DEPTH(RAS_DEPTH)) bus ();

    branch_predict_unit #(
        .BTB_ENTRIES(BTB_ENTRIES),
        .RAS_DEPTH  (RAS_DEPTH)
    ) dut (
        .CLK (clk),
        .RSTN(rstn),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one record per BTB line, RAS as a queue of return addresses.
    typedef struct {
        bit        valid;
        bit [31:0] pc;
        bit [31:0] target;
        int        cnt;
        int        kind;
    } ent_t;
    ent_t      btb [BTB_ENTRIES];
    bit [31:0] ras [$];

    function automatic int idx_of(input bit [31:0] pc);
        return int'((pc / 4) % BTB_ENTRIES);
    endfunction

    function automatic bit same_line(input bit [31:0] a, input bit [31:0] b);
        return (a / (4 * BTB_ENTRIES)) == (b / (4 * BTB_ENTRIES));
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < BTB_ENTRIES; i++) btb[i].valid = 1'b0;
        ras.delete();
    endfunction

    function automatic void model_commit(input bit [31:0] pc, input bit [31:0] tgt,
                                         input bit tk, input bit call, input bit ret);
        int        i;
        int        kind;
        bit [31:0] ra;
        i    = idx_of(pc);
        kind = ret ? K_RET : (call ? K_CALL : K_COND);
        ra   = pc + 32'd4;
        if (btb[i].valid && same_line(btb[i].pc, pc)) begin
            btb[i].cnt  = tk ? ((btb[i].cnt == 3) ? 3 : btb[i].cnt + 1)
                             : ((btb[i].cnt == 0) ? 0 : btb[i].cnt - 1);
            btb[i].kind = kind;
            if (tk) btb[i].target = tgt;
        end else if (tk) begin
            btb[i] = '{valid: 1'b1, pc: pc, target: tgt, cnt: 2, kind: kind};
        end
        if (RAS_ON) begin
            if (call && ret) begin
                if (ras.size() == 0) ras.push_back(ra);
                else ras[ras.size() - 1] = ra;
            end else if (call) begin
                ras.push_back(ra);
                if (ras.size() > RAS_DEPTH) void'(ras.pop_front());
            end else if (ret && ras.size() > 0) begin
                void'(ras.pop_back());
            end
        end
    endfunction

    function automatic void model_predict(input bit [31:0] pc, output bit hit,
                                          output bit tk, output bit [31:0] tgt);
        int i;
        i   = idx_of(pc);
        hit = btb[i].valid && same_line(btb[i].pc, pc);
        tk  = hit && (btb[i].kind != K_COND || btb[i].cnt >= 2);
        tgt = 32'd0;
        if (tk) tgt = (btb[i].kind == K_RET && ras.size() > 0) ? ras[ras.size() - 1] : btb[i].target;
    endfunction

    function automatic logic [RC_W-1:0] model_ras_count();
        return RC_W'(ras.size());
    endfunction

    task automatic set_upd(input bit br, input bit rdy, input bit call, input bit ret,
                           input bit tk, input bit [31:0] pc, input bit [31:0] tgt);
        bus.upd_branch = br;
        bus.upd_ready  = rdy;
        bus.upd_call   = call;
        bus.upd_return = ret;
        bus.upd_taken  = tk;
        bus.upd_pc     = pc;
        bus.upd_target = tgt;
    endtask

    task automatic idle_upd();
        set_upd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // One clock: the model follows whatever the DUT commits at this edge.
    task automatic clk_cycle();
        @(posedge clk);
        if (!rstn) begin
            model_reset();
        end else if (bus.upd_ready && bus.upd_branch) begin
            model_commit(bus.upd_pc, bus.upd_target, bus.upd_taken, bus.upd_call, bus.upd_return);
            $display("commit pc=%08h tgt=%08h taken=%0b call=%0b ret=%0b ras=%0d",
                     bus.upd_pc, bus.upd_target, bus.upd_taken, bus.upd_call,
                     bus.upd_return, ras.size());
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle_upd();
        clk_cycle();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        set_upd(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h180);
        repeat (2) clk_cycle();
        rstn = 1'b1;
        idle_upd();
        bus.fetch_pc = 32'h100;
        #1;
        checks++;
        if (bus.pred_hit !== 1'b0 || bus.pred_taken !== 1'b0 || bus.pred_target !== 32'd0) begin
            errors++;
            $display("FAIL reset_pred got hit=%0b taken=%0b tgt=%08h want 0 0 00000000",
                     bus.pred_hit, bus.pred_taken, bus.pred_target);
        end
        checks++;
        if (bus.ras_count !== '0) begin
            errors++;
            $display("FAIL reset_ras_count got %0d want 0", bus.ras_count);
        end
    endtask

    task automatic test_counter();
        bit [31:0] tgt_seq [6] = '{32'h0, 32'h0, 32'h0, 32'h1c0, 32'h1c0, 32'h1c0};
        bit        tk_seq  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bit        exp_tk  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        set_upd(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h180);
        bus.fetch_pc = 32'h100;
        #1;
        checks++;
        if (bus.pred_hit !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_lookup got hit=%0b want 0", bus.pred_hit);
        end
        clk_cycle();
        idle_upd();
        #1;
        checks++;
        if ({bus.pred_hit, bus.pred_taken, bus.pred_target} !== {1'b1, 1'b1, 32'h180}) begin
            errors++;
            $display("FAIL taken_alloc got hit=%0b taken=%0b tgt=%08h want 1 1 00000180",
                     bus.pred_hit, bus.pred_taken, bus.pred_target);
        end
        // 10 -> 01 -> 00 -> 00 (saturate) -> 01 -> 10 -> 11
        for (int n = 0; n < 6; n++) begin
            set_upd(1'b1, 1'b1, 1'b0, 1'b0, tk_seq[n], 32'h100, tgt_seq[n]);
            clk_cycle();
            idle_upd();
            #1;
            checks++;
            if (bus.pred_hit !== 1'b1 || bus.pred_taken !== exp_tk[n] ||
                bus.pred_target !== (exp_tk[n] ? 32'h1c0 : 32'h0)) begin
                errors++;
                $display("FAIL counter_step%0d got hit=%0b taken=%0b tgt=%08h want taken=%0b",
                         n, bus.pred_hit, bus.pred_taken, bus.pred_target, exp_tk[n]);
            end
        end
        // upper saturation: 11 +1 stays 11, then one not-taken still predicts taken
        set_upd(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h1c0);
        clk_cycle();
        set_upd(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
        clk_cycle();
        idle_upd();
        #1;
        checks++;
        if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h1c0) begin
            errors++;
            $display("FAIL saturate_high got taken=%0b tgt=%08h want 1 000001c0",
                     bus.pred_taken, bus.pred_target);
        end
    endtask

    task automatic test_stall_commit();
        bit        rdy [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        bit        e_hit, e_tk;
        bit [31:0] e_tgt;
        do_reset();
        set_upd(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 32'h340);
        clk_cycle();
        bus.fetch_pc = 32'h300;
        for (int k = 0; k < 4; k++) begin
            set_upd(1'b1, rdy[k], 1'b0, 1'b0, 1'b0, 32'h300, 32'h340);
            #1;
            checks++;
            if (bus.pred_taken !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d got taken=%0b want 1", k, bus.pred_taken);
            end
            clk_cycle();
        end
        set_upd(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 32'h340);
        clk_cycle();
        idle_upd();
        #1;
        checks++;
        if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h340) begin
            errors++;
            $display("FAIL stall_one_step got taken=%0b tgt=%08h want 1 00000340",
                     bus.pred_taken, bus.pred_target);
        end
        bus.fetch_pc = 32'h500;
        for (int k = 0; k < 4; k++) begin
            set_upd(1'b1, rdy[k], 1'b1, 1'b0, 1'b1, 32'h500, 32'h900);
            clk_cycle();
        end
        idle_upd();
        #1;
        checks++;
        if (bus.ras_count !== RC_W'(RAS_ON ? 1 : 0)) begin
            errors++;
            $display("FAIL stall_one_push got ras_count=%0d want %0d", bus.ras_count, RAS_ON ? 1 : 0);
        end
        model_predict(32'h500, e_hit, e_tk, e_tgt);
        checks++;
        if ({bus.pred_hit, bus.pred_taken, bus.pred_target} !== {e_hit, e_tk, e_tgt}) begin
            errors++;
            $display("FAIL stall_call_entry got %0b %0b %08h want %0b %0b %08h",
                     bus.pred_hit, bus.pred_taken, bus.pred_target, e_hit, e_tk, e_tgt);
        end
    endtask

    task automatic test_return_stack();
        bit        op_call [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        bit        op_ret  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        bit [31:0] op_pc   [7] = '{32'h200, 32'h400, 32'h600, 32'h400, 32'h400, 32'h400, 32'h400};
        bit [31:0] op_tgt  [7] = '{32'h800, 32'h204, 32'h800, 32'h204, 32'h204, 32'h204, 32'h204};
        bit        e_hit, e_tk;
        bit [31:0] e_tgt;
        do_reset();
        bus.fetch_pc = 32'h400;
        for (int n = 0; n < 7; n++) begin
            set_upd(1'b1, 1'b1, op_call[n], op_ret[n], 1'b1, op_pc[n], op_tgt[n]);
            clk_cycle();
            idle_upd();
            #1;
            model_predict(32'h400, e_hit, e_tk, e_tgt);
            checks++;
            if ({bus.pred_hit, bus.pred_taken, bus.pred_target} !== {e_hit, e_tk, e_tgt}) begin
                errors++;
                $display("FAIL ras_op%0d_pred got %0b %0b %08h want %0b %0b %08h", n,
                         bus.pred_hit, bus.pred_taken, bus.pred_target, e_hit, e_tk, e_tgt);
            end
            checks++;
            if (bus.ras_count !== model_ras_count()) begin
                errors++;
                $display("FAIL ras_op%0d_count got %0d want %0d", n, bus.ras_count, model_ras_count());
            end
            if (n == 1) begin
                checks++;
                if (bus.pred_target !== 32'h204 || bus.ras_count !== '0) begin
                    errors++;
                    $display("FAIL ret_after_pop got tgt=%08h cnt=%0d want 00000204 0",
                             bus.pred_target, bus.ras_count);
                end
            end
        end
    endtask

    task automatic test_ras_overflow();
        bit [31:0] exp_tgt;
        do_reset();
        set_upd(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2008, 32'hdead0000);
        clk_cycle();
        for (int k = 0; k < 9; k++) begin
            set_upd(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000 + 32'(16 * k), 32'h3000);
            clk_cycle();
        end
        idle_upd();
        #1;
        checks++;
        if (bus.ras_count !== RC_W'(RAS_ON ? RAS_DEPTH : 0)) begin
            errors++;
            $display("FAIL ras_full_count got %0d want %0d", bus.ras_count, RAS_ON ? RAS_DEPTH : 0);
        end
        bus.fetch_pc = 32'h2008;
        for (int k = 0; k < 9; k++) begin
            exp_tgt = (RAS_ON && k < 8) ? 32'h1084 - 32'(16 * k) : 32'hdead0000;
            #1;
            checks++;
            if (bus.pred_taken !== 1'b1 || bus.pred_target !== exp_tgt) begin
                errors++;
                $display("FAIL ras_pop%0d got taken=%0b tgt=%08h want 1 %08h",
                         k, bus.pred_taken, bus.pred_target, exp_tgt);
            end
            set_upd(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2008, 32'hdead0000);
            clk_cycle();
            idle_upd();
        end
        #1;
        checks++;
        if (bus.ras_count !== '0) begin
            errors++;
            $display("FAIL ras_empty_pop got %0d want 0", bus.ras_count);
        end
    endtask

    task automatic test_aliasing();
        do_reset();
        set_upd(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h140);
        clk_cycle();
        set_upd(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100 + 32'(BTB_ENTRIES * 4), 32'h190);
        clk_cycle();
        idle_upd();
        bus.fetch_pc = 32'h100;
        #1;
        checks++;
        if (bus.pred_hit !== 1'b0 || bus.pred_target !== 32'h0) begin
            errors++;
            $display("FAIL alias_evicted got hit=%0b tgt=%08h want 0 00000000",
                     bus.pred_hit, bus.pred_target);
        end
        bus.fetch_pc = 32'h100 + 32'(BTB_ENTRIES * 4);
        #1;
        checks++;
        if (bus.pred_hit !== 1'b1 || bus.pred_target !== 32'h190) begin
            errors++;
            $display("FAIL alias_new got hit=%0b tgt=%08h want 1 00000190",
                     bus.pred_hit, bus.pred_target);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_upd(1'b1, 1'b1, k == 1, 1'b0, 1'b1, 32'h700 + 32'(4 * k), 32'h7f0);
            clk_cycle();
        end
        rstn = 1'b0;
        set_upd(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h710, 32'h7f0);
        clk_cycle();
        rstn = 1'b1;
        idle_upd();
        for (int k = 0; k < 5; k++) begin
            bus.fetch_pc = 32'h700 + 32'(4 * k);
            #1;
            checks++;
            if (bus.pred_hit !== 1'b0 || bus.pred_taken !== 1'b0 || bus.ras_count !== '0) begin
                errors++;
                $display("FAIL midreset_clear%0d got hit=%0b taken=%0b cnt=%0d want 0 0 0",
                         k, bus.pred_hit, bus.pred_taken, bus.ras_count);
            end
        end
    endtask

    task automatic test_random();
        bit        e_hit, e_tk;
        bit [31:0] e_tgt, upc, fpc;
        int        r;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            upc = 32'h100 + 32'(4 * $urandom_range(0, 47));
            fpc = 32'h100 + 32'(4 * $urandom_range(0, 47));
            r   = $urandom_range(0, 9);
            set_upd($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, r == 0 || r == 2,
                    r == 1 || r == 2, $urandom_range(0, 2) != 0, upc, $urandom);
            bus.fetch_pc = fpc;
            #1;
            model_predict(fpc, e_hit, e_tk, e_tgt);
            checks++;
            if ({bus.pred_hit, bus.pred_taken, bus.pred_target} !== {e_hit, e_tk, e_tgt}) begin
                errors++;
                $display("FAIL rand%0d_pred pc=%08h got %0b %0b %08h want %0b %0b %08h", n, fpc,
                         bus.pred_hit, bus.pred_taken, bus.pred_target, e_hit, e_tk, e_tgt);
            end
            checks++;
            if (bus.ras_count !== model_ras_count()) begin
                errors++;
                $display("FAIL rand%0d_count got %0d want %0d", n, bus.ras_count, model_ras_count());
            end
            clk_cycle();
        end
        idle_upd();
    endtask

    initial begin
        idle_upd();
        bus.fetch_pc = 32'h0;
        model_reset();
        test_reset();
        test_counter();
        test_stall_commit();
        test_return_stack();
        test_ras_overflow();
        test_aliasing();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
